// File: rtl/piso_stream.sv
// piso_stream - parametrised parallel-in / serial-out shifter.
//
// A WIDTH-bit word is accepted through a valid/ready load handshake and then
// shifted out one bit per shift_en strobe, MSB- or LSB-first. Completed frames
// are reported by a one-cycle frame_done pulse and a wrapping frame counter.
//
// Optional feature (compile-time macro PISO_STREAM_PARITY_EN): append an even
// parity bit (XOR of all data bits) as an extra shift slot after the data bits.
//
// Handshake: a word transfers on a rising edge where load_valid && load_ready.
// load_ready is combinational and is high in IDLE and on the final shift slot
// of a frame (when shift_en is high), so back-to-back frames run without gaps.
// parallel_in is sampled only on a transfer edge; load_valid while load_ready
// is low is ignored.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-low reset
//   load_valid   in   producer has a word on parallel_in
//   load_ready   out  block can accept a word this cycle
//   parallel_in  in   [WIDTH-1:0] word to serialise
//   shift_en     in   bit-rate strobe, one bit advances per high edge
//   serial_out   out  current serial bit (registered)
//   serial_valid out  serial_out carries a frame bit
//   busy         out  frame in progress
//   frame_done   out  one-cycle pulse after the last slot is shifted out
//   frame_count  out  [CNT_W-1:0] completed frames, wraps modulo 2^CNT_W
module piso_stream #(
   parameter int   WIDTH      = 8,
   parameter bit   MSB_FIRST  = 1'b1,
   parameter logic IDLE_LEVEL = 1'b0,
   parameter int   CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] parallel_in,
   input  logic             shift_en,
   output logic             serial_out,
   output logic             serial_valid,
   output logic             busy,
   output logic             frame_done,
   output logic [CNT_W-1:0] frame_count
);

   localparam int             BCW      = $clog2(WIDTH);
   localparam logic [BCW-1:0] LAST_IDX = BCW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_PARITY = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] sreg_q;
   logic [BCW-1:0]   cnt_q;
   logic             serial_out_q;
   logic             frame_done_q;
   logic [CNT_W-1:0] frame_count_q;
`ifdef PISO_STREAM_PARITY_EN
   logic             parity_q;
`endif

   logic             advance;    // shift to the next data bit
   logic             to_parity;  // last data bit done, parity slot follows
   logic             frame_end;  // final slot of the frame is shifted out
   logic             load_fire;  // handshake on this edge
   logic [WIDTH-1:0] sreg_next;
   logic             next_bit;

   // The front of the shift register is always the bit currently on
   // serial_out; the bit behind it becomes visible after the next shift.
   assign sreg_next = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                                : {1'b0, sreg_q[WIDTH-1:1]};
   assign next_bit  = MSB_FIRST ? sreg_q[WIDTH-2] : sreg_q[1];

   always_comb begin
      advance    = 1'b0;
      to_parity  = 1'b0;
      frame_end  = 1'b0;
      load_ready = 1'b0;
      load_fire  = 1'b0;
      state_d    = state_q;

      case (state_q)
         ST_SHIFT: begin
            if (shift_en) begin
               if (cnt_q == LAST_IDX) begin
`ifdef PISO_STREAM_PARITY_EN
                  to_parity = 1'b1;
`else
                  frame_end = 1'b1;
`endif
               end else begin
                  advance = 1'b1;
               end
            end
         end
         ST_PARITY: begin
`ifdef PISO_STREAM_PARITY_EN
            frame_end = shift_en;
`else
            // Unreachable without the parity feature; fall back to idle.
            frame_end = 1'b1;
`endif
         end
         default: ;
      endcase

      load_ready = reset & ((state_q == ST_IDLE) | frame_end);
      load_fire  = load_valid & load_ready;

      if (load_fire) begin
         state_d = ST_SHIFT;
      end else if (frame_end) begin
         state_d = ST_IDLE;
      end else if (to_parity) begin
         state_d = ST_PARITY;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         sreg_q        <= '0;
         cnt_q         <= '0;
         serial_out_q  <= IDLE_LEVEL;
         frame_done_q  <= 1'b0;
         frame_count_q <= '0;
`ifdef PISO_STREAM_PARITY_EN
         parity_q      <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         frame_done_q <= frame_end;
         if (frame_end) begin
            frame_count_q <= frame_count_q + CNT_W'(1);
         end

         // A load takes priority over the frame-end idle value so that a
         // back-to-back word's first bit follows the previous frame directly.
         if (load_fire) begin
            sreg_q       <= parallel_in;
            cnt_q        <= '0;
            serial_out_q <= MSB_FIRST ? parallel_in[WIDTH-1] : parallel_in[0];
`ifdef PISO_STREAM_PARITY_EN
            parity_q     <= ^parallel_in;
`endif
         end else if (frame_end) begin
            serial_out_q <= IDLE_LEVEL;
         end else if (to_parity) begin
`ifdef PISO_STREAM_PARITY_EN
            serial_out_q <= parity_q;
`endif
         end else if (advance) begin
            sreg_q       <= sreg_next;
            cnt_q        <= cnt_q + BCW'(1);
            serial_out_q <= next_bit;
         end
      end
   end

   assign serial_out   = serial_out_q;
   assign serial_valid = (state_q != ST_IDLE);
   assign busy         = (state_q != ST_IDLE);
   assign frame_done   = frame_done_q;
   assign frame_count  = frame_count_q;

endmodule

// File: doc/piso_stream.md
Name: piso_stream

Overview:
- Parametrised parallel-in/serial-out shifter; successor to the fixed 8-bit PISO.
- Accepts a WIDTH-bit word through a valid/ready load handshake, then shifts it out one bit per shift_en strobe, MSB- or LSB-first.
- Reports frame status and a running frame count.
- Sits between a word-oriented producer and a bit-serial link or test pin.

Parameters:
- WIDTH, 8, data bits per frame (>=2)
- MSB_FIRST, 1, 1 = bit WIDTH-1 first; 0 = bit 0 first
- IDLE_LEVEL, 0, serial_out level when no frame active
- CNT_W, 16, width of frame_count

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- load_valid  in  1  producer has a word on parallel_in
- load_ready  out  1  block can accept a word this cycle
- parallel_in  in  WIDTH  word to serialise; sampled only on handshake
- shift_en  in  1  bit-rate strobe; advance one bit on edges where high
- serial_out  out  1  current serial bit (registered)
- serial_valid  out  1  serial_out carries a frame bit
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after a frame's last bit is shifted out
- frame_count  out  CNT_W  number of completed frames, wraps modulo 2^CNT_W

Behaviour:
- Reset (reset==0 at an edge) sets: serial_out=IDLE_LEVEL, serial_valid=0, busy=0, frame_done=0, frame_count=0, bit counter=0, state=IDLE.
- load_ready is forced 0 while reset==0.
- A reset mid-frame discards the partial frame; frame_count is also cleared.
- States: IDLE, SHIFT (plus PARITY, only when the optional feature is enabled).
- load_ready is combinational: (state==IDLE) OR (state==SHIFT AND last bit AND shift_en). It is 1 in IDLE.
- Handshake occurs on an edge where load_valid && load_ready.
  - parallel_in is captured into the shift register and bit counter is set to 0.
  - state becomes SHIFT.
  - After that edge: serial_out = first bit (parallel_in[WIDTH-1] if MSB_FIRST, else parallel_in[0]), serial_valid=1, busy=1.
- In SHIFT:
  - Each edge with shift_en=1 presents the next bit and increments the counter.
  - Edges with shift_en=0 hold serial_out and the counter unchanged.
- Last bit: counter==WIDTH-1 and shift_en=1 at the edge.
  - Frame completes: frame_done=1 for exactly the following cycle and frame_count increments.
  - If no simultaneous handshake: state goes to IDLE, serial_valid=0, busy=0, serial_out=IDLE_LEVEL.
  - If a simultaneous handshake occurs (back-to-back): the new word loads, its first bit appears after that edge, serial_valid and busy stay 1, and frame_done still pulses.
- Timing with shift_en held at 1: bits are visible for WIDTH consecutive cycles after the load edge E0 (after E0 through after E(WIDTH-1)); frame_done is high after E(WIDTH).
- load_valid while load_ready=0 is ignored; parallel_in is not sampled and the current frame is unaffected.
- shift_en in IDLE has no effect.
- frame_count wraps from 2^CNT_W-1 to 0 with no flag.
- frame_done is registered and never asserts twice in consecutive cycles unless two frames complete on consecutive edges, which requires WIDTH=1 and is excluded by the WIDTH>=2 constraint.

Optional Feature:
- Macro: PISO_STREAM_PARITY_EN.
- Defined:
  - After the last data bit's shift_en edge, state goes to PARITY and serial_out = XOR of all WIDTH data bits (even parity), with serial_valid=1.
  - The frame ends on the next shift_en edge in PARITY; frame_done, frame_count and back-to-back load apply there.
  - "Last bit" for load_ready means PARITY state AND shift_en.
  - Frame length is WIDTH+1 shift slots.
- Not defined:
  - No PARITY state exists; the frame ends after WIDTH data bits as described above.

Test Plan:
- Reset, WIDTH=8, MSB_FIRST=1, shift_en=1, load 8'hAA -> serial_out 1,0,1,0,1,0,1,0 on the 8 cycles after the load edge; then frame_done pulses once, frame_count=1, serial_out=0, busy=0.
- MSB_FIRST=0, load 8'hA5, shift_en=1 -> serial_out 1,0,1,0,0,1,0,1.
- shift_en high only every 4th cycle, load 8'h81 -> each bit held 4 cycles; sequence 1,0,0,0,0,0,0,1; frame_done pulses exactly once.
- Back-to-back: load_valid held high with 8'hF0 then 8'h0F -> 16 contiguous bits 11110000 00001111, serial_valid never drops, two frame_done pulses, frame_count=2.
- Assert reset (reset=0) for 1 cycle after 3 bits of 8'hFF -> next cycle serial_out=IDLE_LEVEL, busy=0, frame_count=0, no frame_done; a fresh load of 8'h3C then serialises correctly.
- PISO_STREAM_PARITY_EN defined, load 8'h07 -> 00000111 then parity bit 1; frame_done after the 9th slot. Load 8'h03 -> parity bit 0.
